// File: rtl/sobel_line_ctrl.sv
// rtl/sobel_line_ctrl.sv - four-line-buffer sequencer and 3x3 window mux for the Sobel stage
module sobel_line_ctrl #(
    parameter int LINE_W = 1280,
    parameter int FILL_W = $clog2(4*LINE_W+1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixel_valid_in,
    input  logic [7:0]  pixel_in,
    input  logic [23:0] lb0_data,
    input  logic [23:0] lb1_data,
    input  logic [23:0] lb2_data,
    input  logic [23:0] lb3_data,
    output logic [3:0]  lb_wr_en,
    output logic [7:0]  lb_wr_data,
    output logic [3:0]  lb_rd_en,
    output logic [71:0] window_out,
    output logic        window_valid,
    output logic        line_done_irq,
    output logic        ovf_err
);
    localparam int CNT_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [FILL_W-1:0] FULL_LVL  = FILL_W'(4*LINE_W);
    localparam logic [FILL_W-1:0] START_LVL = FILL_W'(3*LINE_W);
    localparam logic [CNT_W-1:0]  LAST_COL  = CNT_W'(LINE_W-1);

    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t             state_q;
    logic [1:0]         wr_sel_q, wr_sel_d;
    logic [1:0]         rd_sel_q;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               irq_q;
    logic               ovf_q;
    logic               full;
    logic               wr_acc;
    logic               rd_act;

    always_comb begin
        full     = (fill_q == FULL_LVL);
        wr_acc   = pixel_valid_in && !full;
        rd_act   = (state_q == S_READ);
        lb_wr_en = wr_acc ? (4'b0001 << wr_sel_q) : 4'b0000;

        fill_d = fill_q;
        if (wr_acc && !rd_act)
            fill_d = fill_q + FILL_W'(1);
        else if (!wr_acc && rd_act)
            fill_d = fill_q - FILL_W'(1);

        wr_cnt_d = wr_cnt_q;
        wr_sel_d = wr_sel_q;
        if (wr_acc) begin
            if (wr_cnt_q == LAST_COL) begin
                wr_cnt_d = '0;
                wr_sel_d = wr_sel_q + 2'd1;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end

        // The only buffer not read is the one just before rd_sel, i.e. rd_sel+3.
        lb_rd_en = rd_act ? ~(4'b0001 << (rd_sel_q + 2'd3)) : 4'b0000;

        case (rd_sel_q)
            2'd0:    window_out = {lb0_data, lb1_data, lb2_data};
            2'd1:    window_out = {lb1_data, lb2_data, lb3_data};
            2'd2:    window_out = {lb2_data, lb3_data, lb0_data};
            default: window_out = {lb3_data, lb0_data, lb1_data};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_sel_q <= '0;
            rd_sel_q <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            fill_q   <= '0;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_sel_q <= wr_sel_d;
            wr_cnt_q <= wr_cnt_d;
            fill_q   <= fill_d;
            irq_q    <= 1'b0;
            if (pixel_valid_in && full)
                ovf_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (fill_q >= START_LVL)
                        state_q <= S_READ;
                end
                default: begin
                    if (rd_cnt_q == LAST_COL) begin
                        rd_cnt_q <= '0;
                        rd_sel_q <= rd_sel_q + 2'd1;
                        irq_q    <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign lb_wr_data    = pixel_in;
    assign window_valid  = (state_q == S_READ);
    assign line_done_irq = irq_q;
    assign ovf_err       = ovf_q;
endmodule

// File: tb/tb_sobel_line_ctrl.sv
// tb/tb_sobel_line_ctrl.sv - self-checking bench for sobel_line_ctrl with LINE_W=8
module tb_sobel_line_ctrl;
    localparam int L = 8;
    localparam int FW = $clog2(4*L+1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_valid_in = 1'b0;
    logic [7:0]  pixel_in = '0;
    logic [23:0] lb0_data = '0, lb1_data = '0, lb2_data = '0, lb3_data = '0;
    logic [3:0]  lb_wr_en, lb_rd_en;
    logic [7:0]  lb_wr_data;
    logic [71:0] window_out;
    logic        window_valid, line_done_irq, ovf_err;

    sobel_line_ctrl #(.LINE_W(L), .FILL_W(FW)) dut (
        .clk(clk), .rst(rst), .pixel_valid_in(pixel_valid_in), .pixel_in(pixel_in),
        .lb0_data(lb0_data), .lb1_data(lb1_data), .lb2_data(lb2_data), .lb3_data(lb3_data),
        .lb_wr_en(lb_wr_en), .lb_wr_data(lb_wr_data), .lb_rd_en(lb_rd_en),
        .window_out(window_out), .window_valid(window_valid),
        .line_done_irq(line_done_irq), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pixel and line totals rather than per-buffer counters.
    int m_wr_total, m_fill, m_lines_read, m_rpos;
    bit m_in_read, m_irq, m_ovf;
    logic [23:0] lbd [4];

    logic [3:0] obs_wr, obs_rd;
    bit         obs_wv, obs_irq;
    logic [23:0] obs_top, obs_lb0;

    typedef struct {
        bit         v;
        logic [3:0] wr;
        logic [3:0] rd;
        bit         wv;
        bit         irq;
    } vec_t;
    vec_t tbl [36];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wr_total = 0; m_fill = 0; m_lines_read = 0; m_rpos = 0;
        m_in_read = 0; m_irq = 0; m_ovf = 0;
    endtask

    function automatic logic [3:0] exp_mask(input int rs);
        logic [3:0] m = 4'b0000;
        for (int k = 0; k < 3; k++) m[(rs + k) % 4] = 1'b1;
        return m;
    endfunction

    task automatic step(input bit v);
        bit full, acc;
        int rs, old_fill;
        pixel_valid_in = v;
        pixel_in = 8'($urandom);
        for (int k = 0; k < 4; k++) lbd[k] = 24'($urandom);
        lb0_data = lbd[0]; lb1_data = lbd[1]; lb2_data = lbd[2]; lb3_data = lbd[3];
        #1;
        full = (m_fill == 4*L);
        acc  = v && !full;
        rs   = m_lines_read % 4;
        chk("lb_wr_en", lb_wr_en, acc ? 4'(1 << ((m_wr_total / L) % 4)) : 4'b0000);
        chk("lb_rd_en", lb_rd_en, m_in_read ? exp_mask(rs) : 4'b0000);
        chk("window_valid", window_valid, m_in_read);
        chk("window_out", window_out, {lbd[rs], lbd[(rs+1)%4], lbd[(rs+2)%4]});
        chk("line_done_irq", line_done_irq, m_irq);
        chk("ovf_err", ovf_err, m_ovf);
        chk("lb_wr_data", lb_wr_data, pixel_in);
        chk("fill_cnt", dut.fill_q, m_fill);
        obs_wr = lb_wr_en; obs_rd = lb_rd_en; obs_wv = window_valid; obs_irq = line_done_irq;
        obs_top = window_out[71:48]; obs_lb0 = lb0_data;
        @(posedge clk);
        old_fill = m_fill;
        if (acc) m_wr_total++;
        if (m_in_read) m_fill--;
        if (acc) m_fill++;
        if (v && full) m_ovf = 1;
        m_irq = 0;
        if (m_in_read) begin
            m_rpos++;
            if (m_rpos == L) begin
                m_in_read = 0; m_rpos = 0; m_lines_read++; m_irq = 1;
            end
        end else if (old_fill >= 3*L) begin
            m_in_read = 1;
        end
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst_window_valid", window_valid, 1'b0);
        chk("rst_lb_rd_en", lb_rd_en, 4'b0000);
        chk("rst_lb_wr_en", lb_wr_en, 4'b0000);
        chk("rst_irq", line_done_irq, 1'b0);
        chk("rst_ovf", ovf_err, 1'b0);
        chk("rst_counters", {dut.fill_q, dut.wr_cnt_q, dut.rd_cnt_q, dut.wr_sel_q, dut.rd_sel_q}, '0);
        chk("rst_window_out", window_out, {lb0_data, lb1_data, lb2_data});
    endtask

    // Called just after a rising edge; asserts reset mid-cycle and releases before the next edge.
    task automatic apply_reset();
        pixel_valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_reset_state();
        #1 rst = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 36; i++) begin
            step(tbl[i].v);
            chk({tag, "_wr_en"}, obs_wr, tbl[i].wr);
            chk({tag, "_rd_en"}, obs_rd, tbl[i].rd);
            chk({tag, "_wv"}, obs_wv, tbl[i].wv);
            chk({tag, "_irq"}, obs_irq, tbl[i].irq);
            if (tbl[i].wv) chk({tag, "_top_line0"}, obs_top, obs_lb0);
        end
    endtask

    initial begin
        logic [3:0] starts [$];
        int gaps [$];
        int gap;
        bit prev_wv, seen_read;
        int max_fill;
        bit hit_ovf;

        for (int i = 0; i < 36; i++) begin
            tbl[i].v   = (i < 24);
            tbl[i].wr  = (i < 24) ? 4'(1 << (i / 8)) : 4'b0000;
            tbl[i].wv  = (i >= 25 && i <= 32);
            tbl[i].rd  = tbl[i].wv ? 4'b0111 : 4'b0000;
            tbl[i].irq = (i == 33);
        end

        model_reset();
        #12;
        check_reset_state();
        rst = 1'b0;

        // Scenario 1 from reset
        run_table("s1");

        // Simultaneous write and read keeps fill constant, then async reset mid-READ
        apply_reset();
        for (int i = 0; i < 24; i++) step(1'b1);
        step(1'b0);
        chk("fill_before_wr_rd", dut.fill_q, 6'd24);
        step(1'b1);
        chk("fill_after_wr_rd", dut.fill_q, 6'd24);
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("rd_cnt_mid_read", dut.rd_cnt_q, 3'd4);
        chk("wv_mid_read", window_valid, 1'b1);
        apply_reset();
        run_table("s1_again");

        // Six continuous lines: rd_sel walks 0..3 with one idle cycle between READs
        apply_reset();
        prev_wv = 0; seen_read = 0; gap = 0; max_fill = 0;
        for (int i = 0; i < 80; i++) begin
            step(i < 48);
            if (int'(dut.fill_q) > max_fill) max_fill = int'(dut.fill_q);
            if (obs_wv && !prev_wv) begin
                starts.push_back(obs_rd);
                if (seen_read) gaps.push_back(gap);
                seen_read = 1;
            end
            if (!obs_wv) gap++; else gap = 0;
            prev_wv = obs_wv;
        end
        chk("six_read_count", starts.size(), 4);
        if (starts.size() == 4) begin
            chk("read0_rd_en", starts[0], 4'b0111);
            chk("read1_rd_en", starts[1], 4'b1110);
            chk("read2_rd_en", starts[2], 4'b1101);
            chk("read3_rd_en", starts[3], 4'b1011);
        end
        foreach (gaps[g]) chk("read_gap", gaps[g], 1);
        chk("fill_le_32", max_fill <= 32, 1'b1);
        chk("six_lines_read", m_lines_read, 4);

        // Continuous source eventually overruns; the flag must stick until reset
        apply_reset();
        hit_ovf = 0;
        for (int i = 0; i < 300 && !hit_ovf; i++) begin
            step(1'b1);
            hit_ovf = m_ovf;
        end
        chk("ovf_reached", ovf_err, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b0);
        chk("ovf_sticky", ovf_err, 1'b1);
        apply_reset();

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (i % 500 == 499) apply_reset();
            step($urandom_range(0, 9) < 8);
        end

        apply_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sobel_line_ctrl.md
# sobel_line_ctrl

Controller that sequences the four 8-bit line buffers feeding the Sobel window. It steers the incoming pixel stream into the buffers round-robin, one line each, and tracks buffered fill. Once three full lines are held, it reads them out in lock-step and presents the 3×3 pixel window (72 bits) to the Sobel convolution stage. It pulses an interrupt each time a line has been consumed, so the pixel source can send the next line.

## Interface
- LINE_W, 1280: pixels per line; must match the line buffer depth.
- FILL_W, $clog2(4*LINE_W+1): width of the fill counter (13 bits at the default).
- Clk  in  1  rising-edge clock for all state.
- rst  in  1  asynchronous, active-high reset; also fans out to the line buffers' rst.
- pixel_valid_in  in  1  pixel_in is valid this cycle.
- pixel_in  in  8  incoming grayscale pixel.
- lb0_data, lb1_data, lb2_data, lb3_data  in  24 each  3-pixel taps from line buffers 0..3.
- lb_wr_en  out  4  one-hot per-buffer write strobe (buffer data_valid_in).
- lb_wr_data  out  8  pixel to all buffers; equals pixel_in (combinational).
- lb_rd_en  out  4  per-buffer read-advance strobe (buffer rd_data_in).
- window_out  out  72  {top line 24b, middle 24b, bottom 24b}; oldest line is top.
- window_valid  out  1  window_out is a valid 3×3 window this cycle.
- line_done_irq  out  1  one-cycle pulse when a full output line has been read.
- ovf_err  out  1  sticky flag: a pixel arrived while all four buffers were full.

## Operation
- Write side:
  - wr_sel (2b) selects the target buffer; wr_cnt counts pixels within the current line, 0..LINE_W-1.
  - lb_wr_en = (pixel_valid_in && !full) ? onehot(wr_sel) : 0.
  - On an accepted pixel with wr_cnt == LINE_W-1: wr_cnt←0 and wr_sel←wr_sel+1 (mod 4); otherwise wr_cnt increments.
- Fill counter fill_cnt (FILL_W bits):
  - Write only: +1. Read only: −1. Both in the same cycle: unchanged.
  - full = (fill_cnt == 4*LINE_W). A pixel arriving while full is dropped: no wr_en, counters unchanged, ovf_err←1 until rst.
- FSM, two states:
  - IDLE: when fill_cnt >= 3*LINE_W, go to READ on the next edge.
  - READ: each cycle, rd_cnt increments. When rd_cnt == LINE_W-1: rd_cnt←0, rd_sel←rd_sel+1 (mod 4), line_done_irq←1 on the next cycle, state←IDLE.
- Read side:
  - lb_rd_en = (state==READ) ? mask(rd_sel) : 0, where mask sets bits rd_sel, rd_sel+1, rd_sel+2 (mod 4). Example: rd_sel=2 gives 4'b1101.
  - window_out is a combinational mux of the three buffers, oldest first:
    - rd_sel=0: {lb0,lb1,lb2}
    - rd_sel=1: {lb1,lb2,lb3}
    - rd_sel=2: {lb2,lb3,lb0}
    - rd_sel=3: {lb3,lb0,lb1}
  - window_valid = (state==READ).
- The fourth buffer, not read this line, is normally the write target. Writes continue freely during READ.

## Timing
- Reset values: state=IDLE; wr_sel, rd_sel, wr_cnt, rd_cnt, fill_cnt = 0. lb_wr_en=0, lb_rd_en=0, window_valid=0, line_done_irq=0, ovf_err=0. window_out = {lb0,lb1,lb2} (mux at rd_sel=0).
- Reset mid-line or mid-READ: all state above clears immediately (asynchronous). Any partially buffered data is discarded.
- Write latency: the buffer captures pixel_in on the same edge it is presented (wr_en is combinational).
- Read start: the pixel whose write makes fill_cnt reach 3*LINE_W is accepted at edge N. The FSM enters READ at edge N+1, and window_valid is high from that cycle.
- READ lasts exactly LINE_W cycles with no bubbles. window_valid drops the cycle after the last read.
- line_done_irq: high for exactly the one cycle immediately following the last window_valid cycle of a line.
- Back-to-back lines: after READ→IDLE, if fill_cnt is still >= 3*LINE_W, READ re-enters on the next edge. That leaves one IDLE cycle between lines (window_valid low for one cycle).
- Wrap-around: wr_sel and rd_sel wrap 3→0. The rd_cnt and wr_cnt wraps coincide with their selector advances.

## Test plan
Run all scenarios with LINE_W=8.
- Reset, then 24 consecutive valid pixels:
  - lb_wr_en sequence is 8×0001, 8×0010, 8×0100.
  - window_valid rises one cycle after the 24th pixel and stays high 8 cycles with lb_rd_en=0111.
  - window_out top byte tracks line 0.
  - line_done_irq pulses once.
- Continue streaming a 4th and 5th line:
  - Second READ uses rd_sel=1 (lb_rd_en=1110) and window_out={lb1,lb2,lb3}.
  - The 5th line writes buffer 0.
  - fill_cnt stays at or below 32.
- Write 32 pixels with no reads possible (hold the source through the first READ), then one more pixel:
  - The 33rd pixel produces no lb_wr_en.
  - ovf_err=1 and stays set until rst.
- Simultaneous write and read during READ: fill_cnt stays constant across those cycles (check 24 before and after a write+read cycle).
- Assert rst asynchronously mid-READ at rd_cnt=4:
  - window_valid, lb_rd_en and lb_wr_en drop immediately; all counters read 0.
  - The next 24 pixels reproduce scenario 1 exactly.
- Stream 6 lines (48 pixels) continuously:
  - Observe rd_sel sequence 0,1,2,3 across READs and lb_rd_en=1011 on the 4th READ (rd_sel=3).
  - A one-cycle window_valid gap between consecutive READs.
